// File: rtl/vproc_div_arbiter_if.sv
// Bundle between the divider arbiter, its requesters, the shared divider and the result consumer.
// The arbiter connects through the slave modport; the environment uses master.
interface vproc_div_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high.
  // Requesters hold operands while valid && !ready; req_ready_o depends combinationally on valid.
  logic [NREQ-1:0]            req_valid_i;
  logic [NREQ-1:0]            req_ready_o;
  logic [NREQ-1:0][32:0]      req_op1_i;
  logic [NREQ-1:0][32:0]      req_op2_i;
  logic [NREQ-1:0]            req_mod_i;
  logic [NREQ-1:0][TAG_W-1:0] req_tag_i;
  logic [32:0]                div_op1_o;
  logic [32:0]                div_op2_o;
  logic                       div_mod_o;
  logic [31:0]                div_res_i;
  logic                       res_valid_o;
  logic                       res_ready_i;
  logic [31:0]                res_data_o;
  logic [IDX_W-1:0]           res_idx_o;
  logic [TAG_W-1:0]           res_tag_o;
  logic                       busy_o;

  modport slave (
    input  req_valid_i, req_op1_i, req_op2_i, req_mod_i, req_tag_i, div_res_i, res_ready_i,
    output req_ready_o, div_op1_o, div_op2_o, div_mod_o, res_valid_o, res_data_o, res_idx_o,
           res_tag_o, busy_o
  );

  modport master (
    output req_valid_i, req_op1_i, req_op2_i, req_mod_i, req_tag_i, div_res_i, res_ready_i,
    input  req_ready_o, div_op1_o, div_op2_o, div_mod_o, res_valid_o, res_data_o, res_idx_o,
           res_tag_o, busy_o
  );
endinterface

// File: rtl/vproc_div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency divider among NREQ requesters, with a
// credit-managed first-word-fall-through result FIFO that returns results in issue order.
module vproc_div_arbiter #(
  parameter int NREQ      = 2,
  parameter int DIV_LAT   = 3,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic               clk_i,
  input  logic               sync_rst_i,
  vproc_div_arbiter_if.slave bus
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0]      data;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  entry_t           fifo_q [RES_DEPTH];
  entry_t           fifo_d [RES_DEPTH];

  logic             issue_ok;
  logic             grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] push_idx;
  logic [TAG_W-1:0] push_tag;

  // Credits count ops in flight as well as buffered results, so the FIFO can never overflow.
  assign issue_ok = !sync_rst_i &&
                    (({1'b0, inflight_q} + {1'b0, fifo_count_q}) < SUM_W'(RES_DEPTH));

  always_comb begin
    int cand;
    grant   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant && issue_ok && bus.req_valid_i[IDX_W'(cand)]) begin
        grant   = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    bus.req_ready_o = '0;
    bus.div_op1_o   = '0;
    bus.div_op2_o   = '0;
    bus.div_mod_o   = 1'b0;
    if (grant) begin
      bus.req_ready_o[gnt_idx] = 1'b1;
      bus.div_op1_o            = bus.req_op1_i[gnt_idx];
      bus.div_op2_o            = bus.req_op2_i[gnt_idx];
      bus.div_mod_o            = bus.req_mod_i[gnt_idx];
    end
  end

  generate
    if (DIV_LAT == 0) begin : g_nolat
      assign push     = grant;
      assign push_idx = gnt_idx;
      assign push_tag = bus.req_tag_i[gnt_idx];
    end else begin : g_lat
      // Stage s holds the op whose divider result is due s+1 cycles after issue.
      logic [DIV_LAT-1:0]            vld_q, vld_d;
      logic [DIV_LAT-1:0][IDX_W-1:0] idx_q, idx_d;
      logic [DIV_LAT-1:0][TAG_W-1:0] tag_q, tag_d;

      always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        vld_d[0] = grant;
        idx_d[0] = gnt_idx;
        tag_d[0] = bus.req_tag_i[gnt_idx];
        for (int s = 1; s < DIV_LAT; s++) begin
          vld_d[s] = vld_q[s-1];
          idx_d[s] = idx_q[s-1];
          tag_d[s] = tag_q[s-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (sync_rst_i) vld_q <= '0;
        else            vld_q <= vld_d;
        idx_q <= idx_d;
        tag_q <= tag_d;
      end

      assign push     = vld_q[DIV_LAT-1];
      assign push_idx = idx_q[DIV_LAT-1];
      assign push_tag = tag_q[DIV_LAT-1];
    end
  endgenerate

  assign pop = bus.res_valid_o && bus.res_ready_i;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q].data = bus.div_res_i;
      fifo_d[wr_ptr_q].idx  = push_idx;
      fifo_d[wr_ptr_q].tag  = push_tag;
      wr_ptr_d = (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    inflight_d   = inflight_q + CNT_W'(grant) - CNT_W'(push);
    rr_d         = rr_q;
    if (grant) rr_d = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      rr_q         <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      rr_q         <= rr_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      assert (!(push && fifo_count_q == CNT_W'(RES_DEPTH)));
      assert (!(pop && fifo_count_q == '0));
    end
    fifo_q <= fifo_d;
  end

  assign bus.res_valid_o = !sync_rst_i && (fifo_count_q != '0);
  assign bus.res_data_o  = fifo_q[rd_ptr_q].data;
  assign bus.res_idx_o   = fifo_q[rd_ptr_q].idx;
  assign bus.res_tag_o   = fifo_q[rd_ptr_q].tag;
  assign bus.busy_o      = !sync_rst_i && ((inflight_q != '0) || (fifo_count_q != '0));
endmodule

// File: tb/tb_vproc_div_arbiter.sv
// Directed bench: DUT A (DIV_LAT=3) and DUT B (DIV_LAT=0) in front of behavioural divider models.
module tb_vproc_div_arbiter;
  localparam int NREQ  = 2;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int LAT_A = 3;
  localparam int RW    = 32 + 1 + TAG_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vproc_div_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) ifa ();
  vproc_div_arbiter_if #(.NREQ(NREQ), .TAG_W(TAG_W)) ifb ();

  vproc_div_arbiter #(.NREQ(NREQ), .DIV_LAT(LAT_A), .RES_DEPTH(DEPTH), .TAG_W(TAG_W)) dut_a (
    .clk_i(clk), .sync_rst_i(rst), .bus(ifa)
  );
  vproc_div_arbiter #(.NREQ(NREQ), .DIV_LAT(0), .RES_DEPTH(DEPTH), .TAG_W(TAG_W)) dut_b (
    .clk_i(clk), .sync_rst_i(rst), .bus(ifb)
  );

  // Signed 33-bit divider: x/0 gives all-ones quotient and the dividend as remainder.
  function automatic logic [31:0] div_model(input logic [32:0] op1, input logic [32:0] op2,
                                            input logic md);
    logic signed [32:0] a, b, q, r;
    a = op1;
    b = op2;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return md ? r[31:0] : q[31:0];
  endfunction

  logic [31:0] pipe_a [LAT_A];
  always @(posedge clk) begin
    pipe_a[0] <= div_model(ifa.div_op1_o, ifa.div_op2_o, ifa.div_mod_o);
    for (int s = 1; s < LAT_A; s++) pipe_a[s] <= pipe_a[s-1];
  end
  assign ifa.div_res_i = pipe_a[LAT_A-1];
  assign ifb.div_res_i = div_model(ifb.div_op1_o, ifb.div_op2_o, ifb.div_mod_o);

  // Requesters must hold operands while waiting for a grant.
  logic [NREQ-1:0]            hold_q = '0;
  logic [NREQ-1:0][32:0]      p1_q, p2_q;
  logic [NREQ-1:0]            pm_q;
  logic [NREQ-1:0][TAG_W-1:0] pt_q;
  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (hold_q[i] && ifa.req_valid_i[i] && !rst)
        assert (ifa.req_op1_i[i] == p1_q[i] && ifa.req_op2_i[i] == p2_q[i] &&
                ifa.req_mod_i[i] == pm_q[i] && ifa.req_tag_i[i] == pt_q[i])
          else $error("requester %0d changed operands while waiting", i);
    hold_q <= ifa.req_valid_i & ~ifa.req_ready_o & {NREQ{~rst}};
    p1_q   <= ifa.req_op1_i;
    p2_q   <= ifa.req_op2_i;
    pm_q   <= ifa.req_mod_i;
    pt_q   <= ifa.req_tag_i;
  end

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_req_a(input int i, input logic [32:0] op1, input logic [32:0] op2,
                           input logic md, input logic [TAG_W-1:0] tg);
    ifa.req_op1_i[i] = op1;
    ifa.req_op2_i[i] = op2;
    ifa.req_mod_i[i] = md;
    ifa.req_tag_i[i] = tg;
  endtask

  task automatic issue_a(input string tag, input int i, input logic [32:0] op1,
                         input logic [32:0] op2, input logic md, input logic [TAG_W-1:0] tg);
    cyc();
    set_req_a(i, op1, op2, md, tg);
    ifa.req_valid_i = NREQ'(1 << i);
    @(negedge clk);
    chk(tag, ifa.req_ready_o, NREQ'(1 << i));
    cyc();
    ifa.req_valid_i = '0;
  endtask

  task automatic wait_res_a(input string tag);
    logic [RW-1:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (ifa.res_valid_o !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, ifa.res_valid_o, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk(tag, {ifa.res_data_o, ifa.res_idx_o, ifa.res_tag_o}, e);
  endtask

  task automatic drain_a(input string tag);
    int n;
    n = 0;
    ifa.res_ready_i = 1'b1;
    while (ifa.busy_o !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ifa.busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount, seen;
    logic [31:0] exp_b [8];
    exp_b = '{32'd33, 32'd33, 32'd34, 32'd34, 32'd34, 32'd35, 32'd35, 32'd35};

    // Reset: requests pending, outputs must stay quiet.
    ifa.req_valid_i = '1;
    ifa.req_op1_i   = {33'd9, 33'd9};
    ifa.req_op2_i   = {33'd3, 33'd3};
    ifa.req_mod_i   = '0;
    ifa.req_tag_i   = '0;
    ifa.res_ready_i = 1'b0;
    ifb.req_valid_i = 2'b01;
    ifb.req_op1_i   = {33'd9, 33'd9};
    ifb.req_op2_i   = {33'd3, 33'd3};
    ifb.req_mod_i   = '0;
    ifb.req_tag_i   = '0;
    ifb.res_ready_i = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_ready_a", ifa.req_ready_o, 2'b00);
    chk("rst_valid_a", ifa.res_valid_o, 1'b0);
    chk("rst_busy_a", ifa.busy_o, 1'b0);
    chk("rst_op1_a", ifa.div_op1_o, 33'd0);
    chk("rst_ready_b", ifb.req_ready_o, 2'b00);
    cyc();
    rst = 1'b0;
    ifa.req_valid_i = '0;
    ifb.req_valid_i = '0;

    // Single op latency: 100/7 from req0, tag 5.
    cyc();
    set_req_a(0, 33'd100, 33'd7, 1'b0, 4'd5);
    ifa.req_valid_i = 2'b01;
    @(negedge clk);
    chk("lat_ready", ifa.req_ready_o, 2'b01);
    chk("lat_op1", ifa.div_op1_o, 33'd100);
    chk("lat_op2", ifa.div_op2_o, 33'd7);
    cyc();
    ifa.req_valid_i = '0;
    @(negedge clk);
    chk("lat_t1_valid", ifa.res_valid_o, 1'b0);
    chk("lat_t1_busy", ifa.busy_o, 1'b1);
    cyc();
    cyc();
    @(negedge clk);
    chk("lat_t3_valid", ifa.res_valid_o, 1'b0);
    cyc();
    @(negedge clk);
    chk("lat_t4_valid", ifa.res_valid_o, 1'b1);
    chk("lat_t4_res", {ifa.res_data_o, ifa.res_idx_o, ifa.res_tag_o}, {32'd14, 1'b0, 4'd5});
    ifa.res_ready_i = 1'b1;
    cyc();
    ifa.res_ready_i = 1'b0;
    @(negedge clk);
    chk("lat_pop_valid", ifa.res_valid_o, 1'b0);
    chk("lat_pop_busy", ifa.busy_o, 1'b0);

    // Round robin with both requesters valid; operands change only after a grant.
    do_reset();
    ifa.res_ready_i = 1'b1;
    set_req_a(0, 33'd50, 33'd5, 1'b0, 4'd1);
    set_req_a(1, 33'd60, 33'd4, 1'b0, 4'd2);
    ifa.req_valid_i = 2'b11;
    exp_q.push_back({32'd10, 1'b0, 4'd1});
    exp_q.push_back({32'd15, 1'b1, 4'd2});
    exp_q.push_back({32'd9, 1'b0, 4'd3});
    exp_q.push_back({32'd1, 1'b1, 4'd4});
    @(negedge clk);
    chk("rr_g0", ifa.req_ready_o, 2'b01);
    cyc();
    set_req_a(0, 33'd81, 33'd9, 1'b0, 4'd3);
    @(negedge clk);
    chk("rr_g1", ifa.req_ready_o, 2'b10);
    cyc();
    set_req_a(1, 33'd7, 33'd2, 1'b1, 4'd4);
    @(negedge clk);
    chk("rr_g2", ifa.req_ready_o, 2'b01);
    cyc();
    @(negedge clk);
    chk("rr_g3", ifa.req_ready_o, 2'b10);
    cyc();
    ifa.req_valid_i = '0;
    for (int k = 0; k < 4; k++) wait_res_a($sformatf("rr_res%0d", k));

    // Credit limit with the consumer stalled.
    do_reset();
    ifa.res_ready_i = 1'b0;
    set_req_a(0, 33'd10, 33'd2, 1'b0, 4'd0);
    set_req_a(1, 33'd20, 33'd2, 1'b0, 4'd1);
    ifa.req_valid_i = 2'b11;
    gcount = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ifa.req_ready_o != 2'b00) gcount++;
      cyc();
    end
    chk("full_grants", gcount, 4);
    @(negedge clk);
    chk("full_no_grant", ifa.req_ready_o, 2'b00);
    chk("full_head", {ifa.res_valid_o, ifa.res_data_o, ifa.res_idx_o}, {1'b1, 32'd5, 1'b0});
    ifa.res_ready_i = 1'b1;
    cyc();
    ifa.res_ready_i = 1'b0;
    @(negedge clk);
    chk("credit_grant", ifa.req_ready_o, 2'b01);
    chk("credit_head", {ifa.res_data_o, ifa.res_idx_o}, {32'd10, 1'b1});
    cyc();
    @(negedge clk);
    chk("credit_once", ifa.req_ready_o, 2'b00);
    ifa.req_valid_i = '0;
    drain_a("full_drain");

    // Divide-by-zero and overflow pass through untouched.
    do_reset();
    ifa.res_ready_i = 1'b1;
    exp_q.push_back({32'hFFFF_FFEC, 1'b0, 4'd6});
    issue_a("dz_grant", 0, 33'h1_FFFF_FFEC, 33'd0, 1'b1, 4'd6);
    wait_res_a("dz_res");
    exp_q.push_back({32'h8000_0000, 1'b0, 4'd7});
    issue_a("ovf_grant", 0, 33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0, 4'd7);
    wait_res_a("ovf_res");

    // Reset with ops in flight: results discarded, round robin restarts at 0.
    do_reset();
    ifa.res_ready_i = 1'b1;
    set_req_a(1, 33'd30, 33'd3, 1'b0, 4'd8);
    ifa.req_valid_i = 2'b10;
    @(negedge clk);
    chk("fl_g0", ifa.req_ready_o, 2'b10);
    cyc();
    set_req_a(0, 33'd40, 33'd4, 1'b0, 4'd9);
    ifa.req_valid_i = 2'b11;
    @(negedge clk);
    chk("fl_g1", ifa.req_ready_o, 2'b01);
    cyc();
    ifa.req_valid_i = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("fl_busy", ifa.busy_o, 1'b0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      @(negedge clk);
      if (ifa.res_valid_o !== 1'b0) seen++;
    end
    chk("fl_no_results", seen, 0);
    cyc();
    ifa.req_valid_i = 2'b11;
    @(negedge clk);
    chk("fl_rr_restart", ifa.req_ready_o, 2'b01);
    cyc();
    ifa.req_valid_i = '0;
    drain_a("fl_drain");

    // Zero-latency divider: one grant per cycle, each result one cycle later.
    cyc();
    ifb.res_ready_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        ifb.req_valid_i  = 2'b01;
        ifb.req_op1_i[0] = 33'(100 + k);
        ifb.req_op2_i[0] = 33'd3;
        ifb.req_mod_i[0] = 1'b0;
        ifb.req_tag_i[0] = TAG_W'(k);
      end else begin
        ifb.req_valid_i = '0;
      end
      @(negedge clk);
      if (k < 8) chk($sformatf("z_grant%0d", k), ifb.req_ready_o, 2'b01);
      if (k >= 1)
        chk($sformatf("z_res%0d", k - 1), {ifb.res_valid_o, ifb.res_data_o, ifb.res_tag_o},
            {1'b1, exp_b[k-1], TAG_W'(k - 1)});
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
